// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, WAIT_BUF, DRAIN} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr,pc,pcplus4} holding register for decode stalls
module fetch_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic         clear_i,
  input  logic [W-1:0] instr_i,
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] pcplus4_i,
  output logic         full_o,
  output logic [W-1:0] instr_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pcplus4_o
);
  logic         full_q, full_d;
  logic [W-1:0] instr_q, pc_q, pcplus4_q;
  // clear wins so a redirect can never leave a stale entry behind
  always_comb full_d = clear_i ? 1'b0 : load_i ? 1'b1 : unload_i ? 1'b0 : full_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      pcplus4_q <= '0;
    end else begin
      full_q <= full_d;
      if (load_i && !clear_i) begin
        instr_q   <= instr_i;
        pc_q      <= pc_i;
        pcplus4_q <= pcplus4_i;
      end
    end
  end
  assign full_o    = full_q;
  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and single-outstanding IMEM fetch with skid buffer and redirect drain
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            MisalignE
);
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, drain_addr_q, drain_addr_d, pc_plus4;
  logic [XLEN-1:0] instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic            valid_q, valid_d, misalign_q, misalign_d;
  logic            buf_load, buf_unload, buf_clear, buf_full;
  logic [XLEN-1:0] buf_instr, buf_pc, buf_pcp4;

  assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);
  assign mem_req  = (state_q == FETCH) || (state_q == DRAIN);
  // DRAIN keeps presenting the abandoned address until the memory completes it
  assign mem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pcd_d        = pcd_q;
    pcp4_d       = pcp4_q;
    valid_d      = valid_q;
    misalign_d   = 1'b0;
    buf_load     = 1'b0;
    buf_unload   = 1'b0;
    buf_clear    = 1'b0;
    if (PCSrcE) begin
      pc_d         = {PCTargetE[XLEN-1:2], 2'b00};
      misalign_d   = |PCTargetE[1:0];
      buf_clear    = 1'b1;
      valid_d      = 1'b0;
      state_d      = (mem_req && !mem_ready) ? DRAIN : FETCH;
      drain_addr_d = mem_addr;
    end else begin
      case (state_q)
        BOOT: begin
          state_d = FETCH;
          valid_d = StallD ? valid_q : 1'b0;
        end
        FETCH: begin
          if (mem_ready) begin
            pc_d     = pc_plus4;
            buf_load = StallD || buf_full;
            state_d  = buf_load ? WAIT_BUF : FETCH;
            if (!buf_load) begin
              instr_d = mem_rdata;
              pcd_d   = pc_q;
              pcp4_d  = pc_plus4;
              valid_d = 1'b1;
            end
          end else if (!StallD) valid_d = 1'b0;
        end
        WAIT_BUF: begin
          if (!StallD) begin
            buf_unload = 1'b1;
            instr_d    = buf_instr;
            pcd_d      = buf_pc;
            pcp4_d     = buf_pcp4;
            valid_d    = 1'b1;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          state_d = mem_ready ? FETCH : DRAIN;
          valid_d = StallD ? valid_q : 1'b0;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      instr_q      <= '0;
      pcd_q        <= '0;
      pcp4_q       <= '0;
      valid_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      pcp4_q       <= pcp4_d;
      valid_q      <= valid_d;
      misalign_q   <= misalign_d;
    end
  end

  fetch_skid_buf #(.W(XLEN)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load_i    (buf_load),
    .unload_i  (buf_unload),
    .clear_i   (buf_clear),
    .instr_i   (mem_rdata),
    .pc_i      (pc_q),
    .pcplus4_i (pc_plus4),
    .full_o    (buf_full),
    .instr_o   (buf_instr),
    .pc_o      (buf_pc),
    .pcplus4_o (buf_pcp4)
  );

  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign ValidD    = valid_q;
  assign MisalignE = misalign_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table plus hand-written reset sequences
module tb_fetch_sequencer;
  logic        clk = 1'b0, rst = 1'b1, PCSrcE = 1'b0, StallD = 1'b0, mem_ready = 1'b0;
  logic [31:0] PCTargetE = '0, mem_rdata = '0;
  logic        mem_req, ValidD, MisalignE;
  logic [31:0] mem_addr, InstrD, PCD, PCPlus4D;
  int          checks = 0, errors = 0;

  typedef struct {
    logic        stall, ready, pcsrc;
    logic [31:0] target, rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pcd, pcp4, instr;
    logic        mis;
  } vec_t;
  vec_t vt[21];

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .MisalignE(MisalignE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, r, p, input logic [31:0] t, d,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] pc, p4, in, input logic m);
    vec_t x;
    x.stall = s; x.ready = r; x.pcsrc = p; x.target = t; x.rdata = d;
    x.req = q; x.addr = a; x.valid = v; x.pcd = pc; x.pcp4 = p4; x.instr = in; x.mis = m;
    return x;
  endfunction

  initial begin
    //          stl rdy src target        rdata          req addr          vld pcd           pcp4   instr          mis
    vt[0]  = mk(0, 1, 0, 32'h0,        32'hAA,        1, 32'h0,        0, 32'h0,        32'h0,   32'h0,        0);
    vt[1]  = mk(0, 1, 0, 32'h0,        32'h11,        1, 32'h4,        1, 32'h0,        32'h4,   32'h11,       0);
    vt[2]  = mk(0, 1, 0, 32'h0,        32'h22,        1, 32'h8,        1, 32'h4,        32'h8,   32'h22,       0);
    vt[3]  = mk(1, 1, 0, 32'h0,        32'h00A00093,  0, 32'h0,        1, 32'h4,        32'h8,   32'h22,       0);
    vt[4]  = mk(1, 1, 0, 32'h0,        32'hBAD,       0, 32'h0,        1, 32'h4,        32'h8,   32'h22,       0);
    vt[5]  = mk(1, 0, 0, 32'h0,        32'h0,         0, 32'h0,        1, 32'h4,        32'h8,   32'h22,       0);
    vt[6]  = mk(0, 0, 0, 32'h0,        32'h0,         1, 32'hC,        1, 32'h8,        32'hC,   32'h00A00093, 0);
    vt[7]  = mk(0, 0, 0, 32'h0,        32'h0,         1, 32'hC,        0, 32'h8,        32'hC,   32'h00A00093, 0);
    vt[8]  = mk(0, 0, 1, 32'h40,       32'h0,         1, 32'hC,        0, 32'h8,        32'hC,   32'h00A00093, 0);
    vt[9]  = mk(0, 0, 0, 32'h0,        32'h0,         1, 32'hC,        0, 32'h8,        32'hC,   32'h00A00093, 0);
    vt[10] = mk(0, 1, 0, 32'h0,        32'hDEAD,      1, 32'h40,       0, 32'h8,        32'hC,   32'h00A00093, 0);
    vt[11] = mk(0, 1, 0, 32'h0,        32'h33,        1, 32'h44,       1, 32'h40,       32'h44,  32'h33,       0);
    vt[12] = mk(1, 1, 1, 32'h80,       32'h44,        1, 32'h80,       0, 32'h40,       32'h44,  32'h33,       0);
    vt[13] = mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h80,       0, 32'h40,       32'h44,  32'h33,       0);
    vt[14] = mk(0, 0, 1, 32'h200,      32'h0,         1, 32'h80,       0, 32'h40,       32'h44,  32'h33,       0);
    vt[15] = mk(0, 0, 1, 32'h300,      32'h0,         1, 32'h80,       0, 32'h40,       32'h44,  32'h33,       0);
    vt[16] = mk(0, 1, 0, 32'h0,        32'h77,        1, 32'h300,      0, 32'h40,       32'h44,  32'h33,       0);
    vt[17] = mk(0, 1, 1, 32'h103,      32'h88,        1, 32'h100,      0, 32'h40,       32'h44,  32'h33,       1);
    vt[18] = mk(0, 1, 0, 32'h0,        32'h55,        1, 32'h104,      1, 32'h100,      32'h104, 32'h55,       0);
    vt[19] = mk(0, 1, 1, 32'hFFFFFFFC, 32'h99,        1, 32'hFFFFFFFC, 0, 32'h100,      32'h104, 32'h55,       0);
    vt[20] = mk(0, 1, 0, 32'h0,        32'h66,        1, 32'h0,        1, 32'hFFFFFFFC, 32'h0,   32'h66,       0);

    #2 rst = 1'b0;
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_valid", {31'b0, ValidD}, 32'h0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pcp4", PCPlus4D, 32'h0);
    chk("rst_mis", {31'b0, MisalignE}, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    chk("boot_req", {31'b0, mem_req}, 32'h0);

    for (int i = 0; i < 21; i++) begin
      StallD = vt[i].stall; mem_ready = vt[i].ready; PCSrcE = vt[i].pcsrc;
      PCTargetE = vt[i].target; mem_rdata = vt[i].rdata;
      tick();
      chk($sformatf("v%0d_req", i), {31'b0, mem_req}, {31'b0, vt[i].req});
      if (vt[i].req) chk($sformatf("v%0d_addr", i), mem_addr, vt[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, ValidD}, {31'b0, vt[i].valid});
      chk($sformatf("v%0d_pcd", i), PCD, vt[i].pcd);
      chk($sformatf("v%0d_pcp4", i), PCPlus4D, vt[i].pcp4);
      chk($sformatf("v%0d_instr", i), InstrD, vt[i].instr);
      chk($sformatf("v%0d_mis", i), {31'b0, MisalignE}, {31'b0, vt[i].mis});
    end

    // reset dropped while a request to 0x20 is outstanding
    StallD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h20; mem_ready = 1'b1;
    tick();
    chk("mid_addr", mem_addr, 32'h20);
    PCSrcE = 1'b0; mem_ready = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("mid_req", {31'b0, mem_req}, 32'h0);
    chk("mid_valid", {31'b0, ValidD}, 32'h0);
    chk("mid_pcd", PCD, 32'h0);
    chk("mid_instr", InstrD, 32'h0);
    chk("mid_pcp4", PCPlus4D, 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'hEE;
    tick();
    rst = 1'b1;
    chk("rel_req", {31'b0, mem_req}, 32'h0);
    tick();
    chk("rel_req2", {31'b0, mem_req}, 32'h1);
    chk("rel_addr", mem_addr, 32'h0);
    chk("rel_valid", {31'b0, ValidD}, 32'h0);
    tick();
    chk("rel_pcd", PCD, 32'h0);
    chk("rel_instr", InstrD, 32'hEE);
    chk("rel_pcp4", PCPlus4D, 32'h4);
    chk("rel_valid2", {31'b0, ValidD}, 32'h1);
    chk("rel_addr2", mem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the fetch stage when instruction memory has variable latency.
- Owns the program counter.
- Issues single-outstanding requests to IMEM over a req/ready handshake.
- Absorbs decode stalls with a one-entry skid buffer.
- Applies execute-stage branch redirects, discarding stale responses.
- Drives the IF/ID pipeline outputs (InstrD, PCD, PCPlus4D) plus a valid qualifier.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
XLEN, 32, address/instruction width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
PCSrcE  in  1  redirect request from execute (one-cycle pulse)
PCTargetE  in  XLEN  redirect target address
StallD  in  1  decode stall from hazard unit; hold IF/ID contents
mem_req  out  1  IMEM request valid
mem_addr  out  XLEN  IMEM word address (byte address, bits[1:0]=0)
mem_ready  in  1  IMEM response valid this cycle; completes the request
mem_rdata  in  XLEN  IMEM instruction data, valid when mem_ready=1
InstrD  out  XLEN  instruction to decode
PCD  out  XLEN  PC of InstrD
PCPlus4D  out  XLEN  PCD+4
ValidD  out  1  InstrD/PCD/PCPlus4D hold a real instruction
MisalignE  out  1  one-cycle pulse: PCTargetE[1:0]!=0 on a redirect

Behaviour:
- Reset (rst=0, async) values:
  - PC=RESET_PC, state=BOOT, mem_req=0.
  - InstrD=PCD=PCPlus4D=0, ValidD=0, MisalignE=0.
  - Skid buffer empty.
- States:
  - BOOT: one cycle after reset release, mem_req=0 → FETCH.
  - FETCH: mem_req=1, mem_addr=PC.
  - WAIT_BUF: buffer full, mem_req=0.
  - DRAIN: redirect arrived while a request was outstanding; keep mem_req=1 with the old address until mem_ready, discard the data, then → FETCH at the new PC.
- Handshake:
  - Request completes in the cycle where mem_req=1 and mem_ready=1.
  - mem_addr is stable while mem_req=1 and not yet ready.
  - At most one request is outstanding; mem_req never drops before completion.
- Response in FETCH, no redirect:
  - If StallD=0 and the buffer is empty, load IF/ID next edge: InstrD=mem_rdata, PCD=PC, PCPlus4D=PC+4, ValidD=1.
  - If StallD=1, write the triple to the skid buffer → WAIT_BUF.
  - PC<=PC+4 in both cases. Same-cycle issue of the next request is allowed.
- StallD=1: IF/ID registers hold all values, including ValidD.
- StallD=0 with a non-empty buffer: IF/ID loads from the buffer, buffer empties, WAIT_BUF → FETCH.
- StallD=0, no response, buffer empty: ValidD<=0 (bubble).
- Redirect (PCSrcE=1) has highest priority, over stall and response:
  - PC<=PCTargetE with bits[1:0] forced to 0; MisalignE=1 next cycle if PCTargetE[1:0]!=0.
  - Buffer cleared; ValidD<=0 next edge regardless of StallD.
  - Request in flight, mem_ready=0 → DRAIN.
  - mem_ready=1 in the same cycle → data discarded → FETCH at the target.
- Redirect while in DRAIN: PC updates again, remain in DRAIN.
- PC arithmetic is modulo 2^XLEN: 32'hFFFFFFFC+4 wraps to 0, no flag.
- Reset mid-request:
  - All state clears immediately; mem_req drops asynchronously.
  - A response after reset release is ignored because BOOT issues no request.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum (BOOT, FETCH, WAIT_BUF, DRAIN).
  - Constant INSTR_BYTES=4.
  - Constant NOP_INSTR=32'h00000013, for optional bubble display; ValidD remains authoritative.
- Sub-module fetch_skid_buf: one-entry {instr,pc,pcplus4} buffer with load/unload/clear and full flag.

Test Plan:
1. Reset, mem_ready tied 1, StallD=0 → mem_addr sequence 0,4,8; ValidD high from cycle 3; PCD=0,4,8; PCPlus4D=4,8,12.
2. StallD=1 for 3 cycles while a response (data 32'h00A00093 @PC=8) arrives → IF/ID holds prior values; buffer fills; mem_req=0. StallD=0 → PCD=8, InstrD=32'h00A00093 next edge.
3. mem_ready delayed 3 cycles, PCSrcE=1 with PCTargetE=32'h40 on cycle 1 → old data discarded, ValidD=0; next mem_addr=32'h40; first valid PCD=32'h40.
4. PCSrcE=1 and mem_ready=1 in the same cycle, StallD=1 → response discarded, ValidD=0, buffer empty, next mem_addr=target.
5. PCTargetE=32'h103 → MisalignE pulses one cycle; mem_addr=32'h100.
6. Drop rst mid-request with PC=32'h20 → outputs zero immediately; after release mem_addr=RESET_PC; PC wrap test from 32'hFFFFFFFC gives 0.
